// File: rtl/sprite_draw_engine.sv
// Erases an object's previously drawn bounding box and plots its current one, one pixel per clock.
// Define SPRITE_ERASE_EN to erase the old box before redrawing; otherwise objects leave trails.
module sprite_draw_engine #(
  parameter int         SPR_W      = 8,
  parameter int         SPR_H      = 8,
  parameter int         BUL_W      = 2,
  parameter int         BUL_H      = 4,
  parameter logic [2:0] COL_PLAYER = 3'b010,
  parameter logic [2:0] COL_ENEMY  = 3'b100,
  parameter logic [2:0] COL_BULLET = 3'b110,
  parameter logic [2:0] COL_BG     = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  sel,
  input  logic [7:0]  player_x,
  input  logic [6:0]  player_y,
  input  logic [31:0] enemy_x,
  input  logic [27:0] enemy_y,
  input  logic [3:0]  enemy_alive,
  input  logic [7:0]  bullet_x,
  input  logic [6:0]  bullet_y,
  input  logic        bullet_active,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot,
  output logic        done
);

`ifdef SPRITE_ERASE_EN
  localparam bit ERASE_EN = 1'b1;
`else
  localparam bit ERASE_EN = 1'b0;
`endif
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  typedef enum logic [1:0] {LOAD, ERASE, DRAW, FIN} state_t;
  state_t state;

  // Flatten the per-object inputs into one indexable view (entries 6/7 are unused selectors).
  logic [7:0] obj_x [8];
  logic [6:0] obj_y [8];
  logic [7:0] obj_act;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    obj_act  = '0;
    obj_x[0] = player_x;
    obj_y[0] = player_y;
    obj_act[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      obj_x[k+1]   = enemy_x[8*k +: 8];
      obj_y[k+1]   = enemy_y[7*k +: 7];
      obj_act[k+1] = enemy_alive[k];
    end
    obj_x[5]   = bullet_x;
    obj_y[5]   = bullet_y;
    obj_act[5] = bullet_active;
    obj_x[6]   = '0;
    obj_y[6]   = '0;
    obj_x[7]   = '0;
    obj_y[7]   = '0;
  end

  logic       sel_ok;
  logic [2:0] sidx;
  assign sel_ok = (sel <= 4'd5);
  assign sidx   = sel_ok ? sel[2:0] : 3'd0;

  // Shadow table: last drawn position per object plus a valid bit.
  logic [5:0] shd_valid;
  logic [7:0] shd_x [6];
  logic [6:0] shd_y [6];

  // Per-object working copy captured in LOAD.
  logic       cur_ok, cur_active;
  logic [2:0] cur_idx, cur_colour;
  logic [7:0] cur_x, old_x, box_w;
  logic [6:0] cur_y, old_y, box_h;
  logic [7:0] col;
  logic [6:0] row;

  // NOTE: the shadow positions and working copy carry no reset; only the valid bits
  // (reset below) decide whether a stored position is ever used.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      cur_ok     <= sel_ok;
      cur_idx    <= sidx;
      cur_x      <= obj_x[sidx];
      cur_y      <= obj_y[sidx];
      cur_active <= obj_act[sidx];
      old_x      <= shd_x[sidx];
      old_y      <= shd_y[sidx];
      if (sidx == 3'd5) begin
        box_w      <= 8'(BUL_W);
        box_h      <= 7'(BUL_H);
        cur_colour <= COL_BULLET;
      end else begin
        box_w      <= 8'(SPR_W);
        box_h      <= 7'(SPR_H);
        cur_colour <= (sidx == 3'd0) ? COL_PLAYER : COL_ENEMY;
      end
    end
    if (state == FIN && cur_ok) begin
      shd_x[cur_idx] <= cur_x;
      shd_y[cur_idx] <= cur_y;
    end
  end

  // Addresses are one bit wider than the screen so off-edge pixels clip instead of wrapping.
  logic [8:0] addr_x;
  logic [7:0] addr_y;
  logic       on_screen, last_col, last_px;
  assign addr_x    = {1'b0, (state == ERASE) ? old_x : cur_x} + {1'b0, col};
  assign addr_y    = {1'b0, (state == ERASE) ? old_y : cur_y} + {1'b0, row};
  assign on_screen = (addr_x < 9'(SCR_W)) && (addr_y < 8'(SCR_H));
  assign last_col  = (col == box_w - 8'd1);
  assign last_px   = last_col && (row == box_h - 7'd1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= LOAD;
      col        <= '0;
      row        <= '0;
      shd_valid  <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        LOAD: begin
          col <= '0;
          row <= '0;
          if (!sel_ok)                          state <= FIN;
          else if (ERASE_EN && shd_valid[sidx]) state <= ERASE;
          else if (obj_act[sidx])               state <= DRAW;
          else                                  state <= FIN;
        end
        ERASE, DRAW: begin
          vga_x      <= addr_x[7:0];
          vga_y      <= addr_y[6:0];
          vga_colour <= (state == ERASE) ? COL_BG : cur_colour;
          plot       <= on_screen;
          if (last_px) begin
            col   <= '0;
            row   <= '0;
            state <= (state == ERASE && cur_active) ? DRAW : FIN;
          end else if (last_col) begin
            col <= '0;
            row <= row + 7'd1;
          end else begin
            col <= col + 8'd1;
          end
        end
        FIN: begin
          done <= 1'b1;
          if (cur_ok) shd_valid[cur_idx] <= cur_active;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
